// File: rtl/one_bit_alu.sv
`default_nettype none
// ============================================================================
//  Module      : one_bit_alu
//  Description : Single-bit ALU slice (AND/OR/XOR/ADD with operand inversion)
//                with registered result, zero flag and carry out.
//  Revision    : 1.0  initial release
// ============================================================================
module one_bit_alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       carry_in,
    input  logic [1:0] operation,
    output logic       result,
    output logic       zf,
    output logic       carry_out
);

    localparam logic [1:0] c_OP_AND = 2'b00;
    localparam logic [1:0] c_OP_OR  = 2'b01;
    localparam logic [1:0] c_OP_XOR = 2'b10;
    localparam logic [1:0] c_OP_ADD = 2'b11;

    logic w_aa;
    logic w_bb;
    logic w_next_result;
    logic w_next_carry;

    logic r_result;
    logic r_zf;
    logic r_carry_out;

    // Inversion precedes every operation, so AND with both inverted is NOR.
    assign w_aa = a ^ a_invert;
    assign w_bb = b ^ b_invert;

    always_comb begin
        w_next_result = 1'b0;
        w_next_carry  = 1'b0;
        case (operation)
            c_OP_AND: w_next_result = w_aa & w_bb;
            c_OP_OR:  w_next_result = w_aa | w_bb;
            c_OP_XOR: w_next_result = w_aa ^ w_bb;
            c_OP_ADD: begin
                w_next_result = w_aa ^ w_bb ^ carry_in;
                w_next_carry  = (w_aa & w_bb) | (w_aa & carry_in) | (w_bb & carry_in);
            end
            default: begin
                w_next_result = 1'b0;
                w_next_carry  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result    <= 1'b0;
            r_zf        <= 1'b1;
            r_carry_out <= 1'b0;
        end else begin
            r_result    <= w_next_result;
            r_zf        <= ~w_next_result;
            r_carry_out <= w_next_carry;
        end
    end

    assign result    = r_result;
    assign zf        = r_zf;
    assign carry_out = r_carry_out;

endmodule
`default_nettype wire

// File: tb/tb_one_bit_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_one_bit_alu
//  Description : Directed self-checking bench for one_bit_alu.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_one_bit_alu;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       a_invert;
    logic       b_invert;
    logic       carry_in;
    logic [1:0] operation;
    logic       result;
    logic       zf;
    logic       carry_out;

    int total = 0;
    int bad   = 0;

    one_bit_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .a_invert  (a_invert),
        .b_invert  (b_invert),
        .carry_in  (carry_in),
        .operation (operation),
        .result    (result),
        .zf        (zf),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    // Drive inputs, take one rising edge, then settle 1 time unit before sampling.
    task automatic step(input logic rn, input logic ia, input logic ib,
                        input logic ai, input logic bi, input logic cin,
                        input logic [1:0] op);
        rst_n     = rn;
        a         = ia;
        b         = ib;
        a_invert  = ai;
        b_invert  = bi;
        carry_in  = cin;
        operation = op;
        @(posedge clk);
        #1;
    endtask

    // exp = {result, zf, carry_out}
    task automatic chk(input string tag, input logic [2:0] exp);
        total++;
        assert ({result, zf, carry_out} === exp)
        else begin
            bad++;
            $error("FAIL %s: observed {res,zf,co}=%b expected=%b", tag,
                   {result, zf, carry_out}, exp);
        end
    endtask

    initial begin
        logic [7:0] add_sum;
        logic [7:0] add_cry;
        logic [3:0] and_tt;
        logic [3:0] or_tt;
        logic [3:0] xor_tt;
        logic [2:0] abc;
        logic [1:0] ab;

        // Index i = {a,b,cin} (or {a,b}); bit i holds the hand-computed output.
        add_sum = 8'b1001_0110;
        add_cry = 8'b1110_1000;
        and_tt  = 4'b1000;
        or_tt   = 4'b1110;
        xor_tt  = 4'b0110;

        clk = 1'b0;

        // Reset for two edges with arbitrary inputs
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
        chk("reset_edge1", 3'b010);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
        chk("reset_edge2", 3'b010);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("release_and11", 3'b100);

        // Truth tables, no inversion, cin=0
        for (int i = 0; i < 4; i++) begin
            ab = i[1:0];
            step(1'b1, ab[1], ab[0], 1'b0, 1'b0, 1'b0, 2'b00);
            chk($sformatf("and_%b", ab), {and_tt[i], ~and_tt[i], 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            ab = i[1:0];
            step(1'b1, ab[1], ab[0], 1'b0, 1'b0, 1'b0, 2'b01);
            chk($sformatf("or_%b", ab), {or_tt[i], ~or_tt[i], 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            ab = i[1:0];
            step(1'b1, ab[1], ab[0], 1'b0, 1'b0, 1'b0, 2'b10);
            chk($sformatf("xor_%b", ab), {xor_tt[i], ~xor_tt[i], 1'b0});
        end

        // Full-add sweep
        for (int i = 0; i < 8; i++) begin
            abc = i[2:0];
            step(1'b1, abc[2], abc[1], 1'b0, 1'b0, abc[0], 2'b11);
            chk($sformatf("add_%b", abc), {add_sum[i], ~add_sum[i], add_cry[i]});
        end

        // Inversion: NOR via AND, and 1-1 subtraction
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("nor_00", 3'b100);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11);
        chk("sub_1m1", 3'b011);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
        chk("xor_ainv", 3'b010);

        // carry_in ignored outside ADD
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        chk("xor_cin_ignored", 3'b100);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        chk("and_cin_ignored", 3'b100);

        // Mid-stream reset with op=01, a=1 held
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        chk("or_before_rst", 3'b100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        chk("midstream_rst", 3'b010);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        chk("after_rst", 3'b100);

        // Asynchronous rst_n pulse between edges must not disturb outputs
        rst_n = 1'b0;
        #2;
        chk("async_rst_ignored", 3'b100);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        chk("or_00_after_glitch", 3'b010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
